// File: rtl/dec_seq_to_bin.sv
// Decimal digit stream (MSD first) to binary accumulator with a one-cycle done pulse.
// Define DEC_SEQ_TO_BIN_ERR_EN to reject digits above 9 and flag them on err.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; digits ignored
// S_COLLECT | digit_ready high; accumulating acc = acc*10 + digit
// S_DONE    | one-cycle done pulse; bin_out/err already hold the result
module dec_seq_to_bin #(
  parameter int NDIGITS = 3,
  parameter int OUT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             digit_valid,
  input  logic [3:0]       digit_in,
  input  logic             digit_last,
  output logic             digit_ready,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] bin_out,
  output logic             err
);

  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;
  logic [OUT_W-1:0]   acc_next;
  logic               illegal;
  logic               at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;

    // Modular arithmetic: truncating a wider product to OUT_W gives the same bits.
    acc_next = acc_q * OUT_W'(10) + OUT_W'(digit_in);
    at_limit = (cnt_q == CNT_W'(NDIGITS - 1));
`ifdef DEC_SEQ_TO_BIN_ERR_EN
    illegal = (digit_in > 4'd9);
`else
    illegal = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (digit_valid) begin
          if (illegal) begin
            err_d     = 1'b1;
            bin_out_d = '0;
            state_d   = S_DONE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (digit_last || at_limit) begin
              bin_out_d = acc_next;
              state_d   = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign digit_ready = (state_q == S_COLLECT);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign bin_out     = bin_out_q;
  assign err         = err_q;

endmodule
